mem_bitcount_engine: RTL and testbench

//  Parametrised memory-scanning bit-statistics engine. On start, reads CNT words from

---
 rtl/bitcount_pkg.sv | 18 +
 rtl/word_stat.sv | 42 ++++
 rtl/mem_bitcount_engine.sv | 106 ++++++++++
 tb/tb_mem_bitcount_engine.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bitcount_pkg.sv
// Shared types for the memory bit-statistics engine: statistic selector and FSM states.
package bitcount_pkg;

  typedef enum logic [1:0] {
    MODE_ONES   = 2'b00,
    MODE_ZEROS  = 2'b01,
    MODE_PARITY = 2'b10,
    MODE_LZC    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_FIN  = 2'b11
  } state_t;

endpackage

// File: rtl/word_stat.sv
// Combinational per-word statistic: popcount, zero count, parity or leading-zero count,
// zero-extended to the word width.
module word_stat
  import bitcount_pkg::*;
#(
  parameter int DW = 32
) (
  input  mode_t         mode,
  input  logic [DW-1:0] word,
  output logic [DW-1:0] result
);

  logic [DW-1:0] ones;
  logic [DW-1:0] lz;
  logic          seen;

  always_comb begin
    ones = '0;
    lz   = '0;
    seen = 1'b0;
    for (int unsigned i = 0; i < DW; i++) begin
      ones = ones + DW'(word[i]);
    end
    // Scan from the MSB; an all-zero word counts every bit, giving DW.
    for (int unsigned i = 0; i < DW; i++) begin
      if (word[DW-1-i]) seen = 1'b1;
      else if (!seen)   lz   = lz + DW'(1);
    end
  end

  always_comb begin
    result = '0;
    case (mode)
      MODE_ONES:   result = ones;
      MODE_ZEROS:  result = DW'(DW) - ones;
      MODE_PARITY: result = DW'(^word);
      MODE_LZC:    result = lz;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/mem_bitcount_engine.sv
// Memory-scanning bit-statistics engine: reads cnt words from src_base, writes one
// statistic per word to dst_base and accumulates their sum. Two cycles per word.
module mem_bitcount_engine
  import bitcount_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [AW-1:0]   src_base,
  input  logic [AW-1:0]   dst_base,
  input  logic [CNTW-1:0] cnt,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   total,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_we,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [AW-1:0] STRIDE = AW'(DW / 8);

  state_t          state;
  mode_t           mode_q;
  logic [AW-1:0]   src_q;
  logic [AW-1:0]   dst_q;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] idx;
  logic [CNTW-1:0] idx_next;
  logic [DW-1:0]   stat;

  assign idx_next = idx + CNTW'(1);

  word_stat #(.DW(DW)) u_stat (
    .mode   (mode_q),
    .word   (mem_rdata),
    .result (stat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      total     <= '0;
      idx       <= '0;
      mode_q    <= MODE_ONES;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode_t'(mode);
            src_q  <= src_base;
            dst_q  <= dst_base;
            cnt_q  <= cnt;
            total  <= '0;
            idx    <= '0;
            if (cnt != '0) begin
              mem_addr <= src_base;
              busy     <= 1'b1;
              state    <= S_RD;
            end else begin
              state <= S_FIN;
            end
          end
        end
        S_RD: begin
          mem_wdata <= stat;
          mem_addr  <= dst_q + AW'(idx) * STRIDE;
          mem_we    <= 1'b1;
          total     <= total + stat;
          state     <= S_WR;
        end
        S_WR: begin
          mem_we <= 1'b0;
          idx    <= idx_next;
          if (idx == cnt_q - CNTW'(1)) begin
            state <= S_FIN;
          end else begin
            mem_addr <= src_q + AW'(idx_next) * STRIDE;
            state    <= S_RD;
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bitcount_engine.sv
// Directed bench for mem_bitcount_engine with a word-addressed memory model on dmem.
module tb_mem_bitcount_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] src_base;
  logic [31:0] dst_base;
  logic [7:0]  cnt;
  logic        busy;
  logic        done;
  logic [31:0] total;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];
  int vectors     = 0;
  int miscompares = 0;
  int we_count    = 0;

  mem_bitcount_engine #(.DW(32), .AW(32), .CNTW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mode      (mode),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .cnt       (cnt),
    .busy      (busy),
    .done      (done),
    .total     (total),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      we_count <= we_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency counts the start cycle as cycle 0; returns the cycle in which done is high.
  task automatic run_job(input logic [1:0] m, input logic [31:0] s, input logic [31:0] d,
                         input logic [7:0] c, input bit disturb, output int lat);
    @(negedge clk);
    mode = m; src_base = s; dst_base = d; cnt = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    if (c != 8'd0) chk("busy_after_start", {31'd0, busy}, 32'd1);
    while (!done && lat < 600) begin
      if (disturb && lat == 4) begin
        start = 1'b1; src_base = 32'h0; cnt = 8'd7; mode = 2'b10; dst_base = 32'h0;
      end else if (disturb && lat == 5) begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  logic [31:0] t1_w [20] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000001, 32'h80000000,
                             32'h0000000F, 32'hF0000000, 32'h000000FF, 32'h55555555,
                             32'hAAAAAAAA, 32'h12345678, 32'h0F0F0F0F, 32'hFFFF0000,
                             32'h00010001, 32'h7FFFFFFF, 32'hDEADBEEF, 32'h00000003,
                             32'hC0000000, 32'h01010101, 32'h11111111, 32'hFFFFFFFE};
  logic [31:0] t1_e [20] = '{0, 32, 1, 1, 4, 4, 8, 16, 16, 13, 16, 16, 2, 31, 24, 2, 2, 4, 8, 31};
  logic [31:0] t2_e [4]  = '{32, 31, 0, 15};
  logic [31:0] t6_e [4]  = '{0, 1, 1, 1};

  initial begin
    int lat;
    int wc0;
    int pulses;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 20; i++) mem[i] = t1_w[i];
    mem[64] = 32'h00000000; mem[65] = 32'h00000001;
    mem[66] = 32'h80000000; mem[67] = 32'h00010000;
    mem[96] = 32'hF0F0F0F1;
    for (int i = 200; i < 210; i++) mem[i] = 32'hA5A5A5A5;

    reset = 1'b1; start = 1'b0; mode = 2'b00; src_base = '0; dst_base = '0; cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, busy},   32'd0);
    chk("rst_done",  {31'd0, done},   32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_addr",  mem_addr,        32'd0);
    chk("rst_wdata", mem_wdata,       32'd0);
    chk("rst_total", total,           32'd0);
    reset = 1'b0;

    // Popcount over 20 words, results at byte 80 onwards
    run_job(2'b00, 32'd0, 32'd80, 8'd20, 1'b0, lat);
    chk("t1_latency", lat, 42);
    chk("t1_total", total, 32'd231);
    chk("t1_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
    for (int i = 0; i < 20; i++) chk($sformatf("t1_res%0d", i), mem[20+i], t1_e[i]);

    // Leading-zero count
    run_job(2'b11, 32'h100, 32'h200, 8'd4, 1'b0, lat);
    chk("t2_latency", lat, 10);
    chk("t2_total", total, 32'd78);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_res%0d", i), mem[128+i], t2_e[i]);

    // Zeros and parity on the same word
    run_job(2'b01, 32'h180, 32'h1C0, 8'd1, 1'b0, lat);
    chk("t3_zeros_latency", lat, 4);
    chk("t3_zeros_res", mem[112], 32'd15);
    chk("t3_zeros_total", total, 32'd15);
    run_job(2'b10, 32'h180, 32'h1C4, 8'd1, 1'b0, lat);
    chk("t3_parity_res", mem[113], 32'd1);
    chk("t3_parity_total", total, 32'd1);

    // Zero-length job
    wc0 = we_count;
    run_job(2'b00, 32'h0, 32'h3F0, 8'd0, 1'b0, lat);
    chk("t4_latency", lat, 2);
    chk("t4_total", total, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_no_writes", we_count - wc0, 0);

    // start while busy with changed operands must be ignored
    wc0 = we_count;
    run_job(2'b00, 32'h100, 32'h300, 8'd4, 1'b1, lat);
    chk("t5_latency", lat, 10);
    chk("t5_total", total, 32'd3);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_res%0d", i), mem[192+i], t6_e[i]);
    repeat (20) @(negedge clk);
    chk("t5_write_count", we_count - wc0, 4);
    chk("t5_idle_after", {31'd0, busy}, 32'd0);

    // Reset during the WR cycle of the 5th word
    @(negedge clk);
    mode = 2'b00; src_base = 32'h0; dst_base = 32'd800; cnt = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("t6_we_in_wr", {31'd0, mem_we}, 32'd1);
    chk("t6_wr_addr", mem_addr, 32'd816);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_we_after_rst", {31'd0, mem_we}, 32'd0);
    chk("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    chk("t6_total_after_rst", total, 32'd0);
    wc0 = we_count;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t6_no_done", pulses, 0);
    chk("t6_no_writes", we_count - wc0, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_written%0d", i), mem[200+i], t1_e[i]);
    for (int i = 5; i < 10; i++) chk($sformatf("t6_untouched%0d", i), mem[200+i], 32'hA5A5A5A5);

    // Fresh job after the abort, parity over the t2 words
    run_job(2'b10, 32'h100, 32'h3C0, 8'd4, 1'b0, lat);
    chk("t6b_latency", lat, 10);
    chk("t6b_total", total, 32'd3);
    for (int i = 0; i < 4; i++) chk($sformatf("t6b_res%0d", i), mem[240+i], t6_e[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
